// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coin_pkg
//  Purpose  : Shared coin codes, acceptor state encoding and sensor helpers
//  Revision : 1.0 - initial release
// ============================================================================
package coin_pkg;

    // Coin codes shared with the downstream vending FSM.
    localparam logic [1:0] COIN_A    = 2'b00;
    localparam logic [1:0] COIN_B    = 2'b01;
    localparam logic [1:0] COIN_C    = 2'b10;
    localparam logic [1:0] COIN_NONE = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUAL     = 3'd1,
        HOLD     = 3'd2,
        EMIT     = 3'd3,
        REJ_WAIT = 3'd4,
        JAM      = 3'd5
    } state_t;

    // True when exactly one of the three sensors is high.
    function automatic logic is_single(input logic [2:0] s);
        return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
    endfunction

    // Map a one-hot sensor mask {c,b,a} to its coin code.
    function automatic logic [1:0] sensor_code(input logic [2:0] sel);
        logic [1:0] code;
        code = COIN_NONE;
        case (sel)
            3'b001:  code = COIN_A;
            3'b010:  code = COIN_B;
            3'b100:  code = COIN_C;
            default: code = COIN_NONE;
        endcase
        return code;
    endfunction

endpackage : coin_pkg
`default_nettype wire

// File: rtl/coin_acceptor_if.sv
`default_nettype none
// ============================================================================
//  Module   : coin_acceptor_if
//  Purpose  : Sensor inputs and coin/reject/jam outputs of the coin acceptor
//  Revision : 1.0 - initial release
// ============================================================================
interface coin_acceptor_if;

    logic       sns_a;
    logic       sns_b;
    logic       sns_c;
    logic       accept_en;
    logic [1:0] coin;
    logic       coin_vld;
    logic       reject;
    logic       jam;

    // Sensor/controller side driving the acceptor.
    modport master (
        output sns_a, sns_b, sns_c, accept_en,
        input  coin, coin_vld, reject, jam
    );

    // The acceptor itself.
    modport slave (
        input  sns_a, sns_b, sns_c, accept_en,
        output coin, coin_vld, reject, jam
    );

endinterface : coin_acceptor_if
`default_nettype wire

// File: rtl/coin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : coin_sync
//  Purpose  : 1-bit two-flop synchronizer, asynchronous active-low reset to 0
//  Revision : 1.0 - initial release
// ============================================================================
module coin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : coin_sync
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module   : coin_acceptor
//  Purpose  : Synchronizes three coin sensors, qualifies pulses by width and
//             emits one-cycle coin codes, reject pulses and a jam level.
//  Revision : 1.0 - initial release
// ============================================================================
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYC = 4,
    parameter int MAX_CYC = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    coin_acceptor_if.slave bus
);

    localparam int              CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [2:0]       raw_w;
    logic [2:0]       sns_s;      // synced sensors {s_c, s_b, s_a}
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       sel_q, sel_d; // one-hot latched sensor
    logic [1:0]       coin_q, coin_d;
    logic             vld_q, vld_d;
    logic             rej_q, rej_d;
    logic             jam_q, jam_d;
    logic             any_hi, lat_hi, oth_hi;

    assign raw_w = {bus.sns_c, bus.sns_b, bus.sns_a};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            coin_sync u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (raw_w[gi]),
                .q_o   (sns_s[gi])
            );
        end
    endgenerate

    assign any_hi  = |sns_s;
    assign lat_hi  = |(sns_s & sel_q);
    assign oth_hi  = |(sns_s & ~sel_q);
    // Counter saturates at MAX_CYC so it can never wrap.
    assign cnt_inc = (cnt_q == MAX_C) ? MAX_C : cnt_q + ONE_C;

    // State, counter, latched sensor and all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 3'b000;
            coin_q  <= COIN_NONE;
            vld_q   <= 1'b0;
            rej_q   <= 1'b0;
            jam_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            coin_q  <= coin_d;
            vld_q   <= vld_d;
            rej_q   <= rej_d;
            jam_q   <= jam_d;
        end
    end

    // Next state and next outputs. Outputs are computed for the state being
    // entered, so they are visible in that state's cycle without extra delay;
    // the accept/return decision uses accept_en on the edge that enters EMIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        coin_d  = COIN_NONE;
        vld_d   = 1'b0;
        rej_d   = 1'b0;
        jam_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_single(sns_s)) begin
                    sel_d   = sns_s;
                    cnt_d   = ONE_C;
                    state_d = QUAL;
                end else if (any_hi) begin
                    cnt_d   = '0;
                    rej_d   = 1'b1;
                    state_d = REJ_WAIT;
                end
            end

            QUAL: begin
                if (oth_hi) begin
                    cnt_d   = '0;
                    rej_d   = 1'b1;
                    state_d = REJ_WAIT;
                end else if (!lat_hi) begin
                    // Too short: a glitch, dropped silently.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_C) begin
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (oth_hi) begin
                    cnt_d   = '0;
                    rej_d   = 1'b1;
                    state_d = REJ_WAIT;
                end else if (!lat_hi) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                    if (bus.accept_en) begin
                        coin_d = sensor_code(sel_q);
                        vld_d  = 1'b1;
                    end else begin
                        rej_d  = 1'b1;
                    end
                end else if (cnt_inc == MAX_C) begin
                    // High for MAX_CYC cycles: stuck sensor, reuse the
                    // counter for the all-low release count.
                    cnt_d   = '0;
                    jam_d   = 1'b1;
                    state_d = JAM;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            EMIT: begin
                state_d = IDLE;
            end

            REJ_WAIT: begin
                if (any_hi) begin
                    cnt_d = '0;
                end else if (cnt_inc == DEB_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            JAM: begin
                jam_d = 1'b1;
                if (any_hi) begin
                    cnt_d = '0;
                end else if (cnt_inc == DEB_C) begin
                    cnt_d   = '0;
                    jam_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.coin     = coin_q;
    assign bus.coin_vld = vld_q;
    assign bus.reject   = rej_q;
    assign bus.jam      = jam_q;

endmodule : coin_acceptor
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coin_acceptor
//  Purpose  : Self-checking bench for coin_acceptor (DEB_CYC=4, MAX_CYC=20)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int DEB = 4;
    localparam int MAX = 20;
    localparam int NR  = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    coin_acceptor_if bus ();

    coin_acceptor #(
        .DEB_CYC (DEB),
        .MAX_CYC (MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observation accumulators for one pulse window.
    int         n_vld, n_rej, n_jam, t_evt, n_bad;
    logic [1:0] last_code;

    typedef struct {
        logic [2:0] mask;
        int         w;
        logic       acc;
        int         e_vld;
        logic [1:0] e_code;
        int         e_rej;
        int         e_jam;
        int         e_t;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_raw(input logic [2:0] m);
        bus.sns_a = m[0];
        bus.sns_b = m[1];
        bus.sns_c = m[2];
    endtask

    task automatic clear_obs();
        n_vld = 0; n_rej = 0; n_jam = 0; t_evt = 0; n_bad = 0;
        last_code = COIN_NONE;
    endtask

    // Advance one edge and sample outputs 1 ns later.
    task automatic step(input int t);
        @(posedge clk);
        #1;
        if (bus.coin_vld === 1'b1) begin
            n_vld++;
            last_code = bus.coin;
            if (t_evt == 0) t_evt = t;
        end
        if (bus.reject === 1'b1) begin
            n_rej++;
            if (t_evt == 0) t_evt = t;
        end
        if (bus.jam === 1'b1) begin
            n_jam++;
            if (t_evt == 0) t_evt = t;
        end
        if (bus.coin_vld !== (bus.coin != COIN_NONE)) n_bad++;
    endtask

    // Raw pulse of width w on mask starting at t=1, then a quiet tail.
    task automatic run_pulse(input logic [2:0] mask, input int w, input logic acc);
        clear_obs();
        bus.accept_en = acc;
        for (int t = 1; t <= w + DEB + 8; t++) begin
            set_raw((t <= w) ? mask : 3'b000);
            step(t);
        end
    endtask

    // Random schedule and expected per-edge outputs {coin, vld, rej, jam}.
    logic [2:0] sch_raw [NR];
    logic       sch_acc [NR];
    logic [4:0] sch_exp [NR];

    function automatic int popc(input logic [2:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]);
    endfunction

    // Expected outputs follow from the pulse rules: a rise at edge r is seen
    // by the qualifier on edge r+2, so a coin of width w resolves on edge
    // r+w+2, a multi-sensor event rejects on r+2, and a jam is flagged from
    // the MAX-th synced-high cycle until DEB low cycles after release.
    task automatic build_schedule();
        logic [2:0] duals [4];
        int t, w, gap, kind, n;
        logic [2:0] m;
        logic a;
        duals = '{3'b011, 3'b101, 3'b110, 3'b111};
        for (int i = 0; i < NR; i++) begin
            sch_raw[i] = 3'b000;
            sch_acc[i] = 1'b0;
            sch_exp[i] = {COIN_NONE, 3'b000};
        end
        t = 1;
        while (t + 60 < NR) begin
            kind = int'($urandom_range(0, 4));
            gap  = int'($urandom_range(DEB + 3, DEB + 8));
            a    = 1'($urandom_range(0, 1));
            m    = 3'b001 << $urandom_range(0, 2);
            case (kind)
                0: w = int'($urandom_range(1, DEB - 1));
                1: w = int'($urandom_range(DEB, MAX - 1));
                2: begin
                    n = int'($urandom_range(0, 2));
                    w = (n == 0) ? DEB : ((n == 1) ? MAX - 1 : MAX);
                end
                3: w = int'($urandom_range(MAX, MAX + 6));
                default: begin
                    w = int'($urandom_range(1, 8));
                    m = duals[$urandom_range(0, 3)];
                end
            endcase
            for (int k = t; k < t + w; k++) sch_raw[k] = m;
            for (int k = t; k < t + w + gap; k++) sch_acc[k] = a;
            if (popc(m) > 1) begin
                sch_exp[t + 2] = {COIN_NONE, 3'b010};
            end else if (w >= MAX) begin
                for (int k = t + 1 + MAX; k <= t + w + DEB; k++) sch_exp[k] = {COIN_NONE, 3'b001};
            end else if (w >= DEB) begin
                sch_exp[t + w + 2] = a ? {sensor_code(m), 3'b100} : {COIN_NONE, 3'b010};
            end
            t = t + w + gap;
        end
    endtask

    initial begin
        vec_t vecs [13];
        vecs[0]  = '{3'b010,  8, 1'b1, 1, COIN_B,    0, 0, 11};
        vecs[1]  = '{3'b001,  2, 1'b1, 0, COIN_NONE, 0, 0,  0};
        vecs[2]  = '{3'b001,  6, 1'b1, 1, COIN_A,    0, 0,  9};
        vecs[3]  = '{3'b101,  5, 1'b1, 0, COIN_NONE, 1, 0,  3};
        vecs[4]  = '{3'b100,  6, 1'b1, 1, COIN_C,    0, 0,  9};
        vecs[5]  = '{3'b100, 25, 1'b1, 0, COIN_NONE, 0, 9, 22};
        vecs[6]  = '{3'b010,  6, 1'b0, 0, COIN_NONE, 1, 0,  9};
        vecs[7]  = '{3'b010,  6, 1'b1, 1, COIN_B,    0, 0,  9};
        vecs[8]  = '{3'b010,  4, 1'b1, 1, COIN_B,    0, 0,  7};
        vecs[9]  = '{3'b010,  3, 1'b1, 0, COIN_NONE, 0, 0,  0};
        vecs[10] = '{3'b001, 19, 1'b1, 1, COIN_A,    0, 0, 22};
        vecs[11] = '{3'b001, 20, 1'b1, 0, COIN_NONE, 0, 4, 22};
        vecs[12] = '{3'b111,  3, 1'b0, 0, COIN_NONE, 1, 0,  3};

        set_raw(3'b000);
        bus.accept_en = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset coin", 32'(bus.coin), 32'(COIN_NONE));
        check("reset coin_vld", 32'(bus.coin_vld), 32'd0);
        check("reset reject", 32'(bus.reject), 32'd0);
        check("reset jam", 32'(bus.jam), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(0);

        // Directed pulse table.
        for (int i = 0; i < 13; i++) begin
            run_pulse(vecs[i].mask, vecs[i].w, vecs[i].acc);
            check($sformatf("vec%0d vld count", i), 32'(n_vld), 32'(vecs[i].e_vld));
            check($sformatf("vec%0d coin code", i), 32'(last_code), 32'(vecs[i].e_code));
            check($sformatf("vec%0d reject count", i), 32'(n_rej), 32'(vecs[i].e_rej));
            check($sformatf("vec%0d jam cycles", i), 32'(n_jam), 32'(vecs[i].e_jam));
            check($sformatf("vec%0d event time", i), 32'(t_evt), 32'(vecs[i].e_t));
            check($sformatf("vec%0d idle coin", i), 32'(n_bad), 32'd0);
        end

        // Reset while jammed clears jam asynchronously, before any edge.
        clear_obs();
        bus.accept_en = 1'b1;
        set_raw(3'b001);
        for (int t = 1; t <= 24; t++) step(t);
        check("jam before reset", 32'(bus.jam), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset jam", 32'(bus.jam), 32'd0);
        check("async reset coin", 32'(bus.coin), 32'(COIN_NONE));
        set_raw(3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        for (int t = 1; t <= 10; t++) step(t);
        check("post-jam-reset quiet", 32'(n_vld + n_rej + n_jam), 32'd0);

        // Reset mid-HOLD with the sensor still high: coin re-qualified once.
        clear_obs();
        set_raw(3'b001);
        for (int t = 1; t <= 8; t++) step(t);
        #3;
        rst_n = 1'b0;
        #1;
        check("hold reset outputs", 32'({bus.coin, bus.coin_vld, bus.reject, bus.jam}),
              32'({COIN_NONE, 3'b000}));
        check("hold reset no output", 32'(n_vld + n_rej + n_jam), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        for (int t = 1; t <= 20; t++) begin
            set_raw((t <= 6) ? 3'b001 : 3'b000);
            step(t);
        end
        check("requal vld count", 32'(n_vld), 32'd1);
        check("requal coin code", 32'(last_code), 32'(COIN_A));
        check("requal no reject", 32'(n_rej + n_jam), 32'd0);

        // Randomized schedule against the pulse-rule model.
        build_schedule();
        for (int t = 1; t < NR; t++) begin
            set_raw(sch_raw[t]);
            bus.accept_en = sch_acc[t];
            @(posedge clk);
            #1;
            check($sformatf("rand t%0d {coin,vld,rej,jam}", t),
                  32'({bus.coin, bus.coin_vld, bus.reject, bus.jam}), 32'(sch_exp[t]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_coin_acceptor
`default_nettype wire

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end for the vending controller: it conditions three raw, asynchronous coin-sensor lines and qualifies each coin by pulse width. Each accepted coin is emitted as a one-cycle 2-bit coin code on `coin`. Glitches, multi-sensor events and jams are filtered out. Between coins, `coin` idles at 2'b11, which the controller treats as "no coin".

Parameters:
- DEB_CYC, 4: consecutive synced-high cycles needed to qualify a sensor; also the all-low cycles needed to leave REJ_WAIT or JAM (range 2..255).
- MAX_CYC, 1000: maximum total high time, in cycles, before a jam is declared (must be > DEB_CYC).
- CNT_W, $clog2(MAX_CYC+1): width of the internal counter (derived, not overridden).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- sns_a, input, 1: raw sensor, small coin, async.
- sns_b, input, 1: raw sensor, medium coin, async.
- sns_c, input, 1: raw sensor, large coin, async.
- accept_en, input, 1: controller ready to take a coin; sampled only in EMIT.
- coin, output, 2: coin code (a=2'b00, b=2'b01, c=2'b10, none=2'b11).
- coin_vld, output, 1: one-cycle strobe; high exactly while `coin` != 2'b11.
- reject, output, 1: one-cycle pulse; coin routed to the return chute.
- jam, output, 1: level; sensor stuck.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE, counter=0, coin=2'b11, coin_vld=0, reject=0, jam=0, synchronizer flops=0. Reset mid-coin discards the coin with no output.
- Synchronization: each sns_* passes through a 2-flop synchronizer. All logic below uses the synced values s_a, s_b, s_c.
- All outputs are registered. `coin` returns to 2'b11 in every cycle where coin_vld=0.
- IDLE:
  - Exactly one of s_a/s_b/s_c high: latch its code and go to QUAL with cnt=1.
  - Two or more high: go to REJ_WAIT.
- QUAL:
  - Latched sensor high and others low: cnt++. When cnt==DEB_CYC, go to HOLD.
  - Latched sensor low: glitch; return to IDLE with no output.
  - Any other sensor high: go to REJ_WAIT.
- HOLD:
  - Counting continues. When cnt reaches MAX_CYC with the sensor still high, go to JAM.
  - Another sensor high: go to REJ_WAIT.
  - Latched sensor low: go to EMIT.
- EMIT (exactly 1 cycle):
  - accept_en=1: coin=latched code, coin_vld=1.
  - accept_en=0: reject=1 and coin stays 2'b11.
  - Next state is IDLE.
- REJ_WAIT:
  - reject=1 in the first cycle only.
  - Stay until all sensors are low for DEB_CYC consecutive cycles; any high restarts the count. Then go to IDLE.
- JAM:
  - jam=1 for the whole time in this state; no reject pulse.
  - Exit to IDLE after all sensors are low for DEB_CYC consecutive cycles; jam=0 from the IDLE cycle on.
- Latency: coin_vld asserts in the cycle after the 3rd rising clk edge counted from the first edge that samples the raw sensor low.
- Minimum accepted pulse: DEB_CYC synced-high cycles. A high time equal to MAX_CYC is a jam, not a coin.
- Back-to-back coins: a new sensor rise seen in the EMIT cycle is ignored until IDLE. Raw pulses are spaced at ≥2 cycles by the mechanics, so no coin is lost.
- Counter saturates at MAX_CYC and never wraps.

Decomposition:
- Package coin_pkg:
  - COIN_A=2'b00, COIN_B=2'b01, COIN_C=2'b10, COIN_NONE=2'b11. The downstream vending FSM shares these constants.
  - State encoding enum: IDLE, QUAL, HOLD, EMIT, REJ_WAIT, JAM (3 bits).
- Sub-module: coin_sync, a 1-bit 2-flop synchronizer with async active-low reset to 0, instantiated three times.

Test Plan (DEB_CYC=4, MAX_CYC=20):
1. sns_b high 8 cycles then low, accept_en=1 -> one cycle of coin=2'b01 with coin_vld=1, 3 cycles after the fall; coin=2'b11 on every other cycle; reject=0.
2. sns_a high 2 cycles (glitch) -> no coin_vld, no reject; state back in IDLE; a following 6-cycle sns_a pulse yields coin=2'b00.
3. sns_a and sns_c rise on the same edge, held 5 cycles -> one reject pulse, no coin_vld; only a clean sns_c pulse after 4 low cycles is accepted, as coin=2'b10.
4. sns_c held 25 cycles -> jam=1 from synced-high cycle 20; release, then after 4 low cycles jam=0; no coin_vld and no reject at any point.
5. sns_b 6-cycle pulse with accept_en=0 during EMIT -> reject=1 for 1 cycle, coin stays 2'b11; repeat with accept_en=1 -> coin=2'b01.
6. rst_n asserted low mid-HOLD on sns_a -> all outputs at reset values immediately (async); after release with sns_a still high, the coin is re-qualified from IDLE; no spurious coin_vld.
